// File: rtl/topaz_geyser_pkg.sv
// Shared types and constants for the RV32E fetch front end.
package topaz_geyser_pkg;

  localparam int          XLEN = 32;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0] pc0;
    logic [31:0]     instr;
  } fetch_entry_t;

  // Sequential PC step; wraps naturally modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + {{(XLEN-3){1'b0}}, 3'd4};
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch entries; flush beats push and pop.
module fetch_queue
  import topaz_geyser_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1),
  localparam int PW    = $clog2(DEPTH)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush_i,
  input  logic         push_i,
  input  fetch_entry_t push_data_i,
  input  logic         pop_i,
  output logic [CW-1:0] count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          write_s;

  assign write_s = rst_n & ~flush_i & push_i;

  // Next pointer/occupancy; pointers wrap because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) begin
        wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  // Pointer and occupancy registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (write_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch PC, credit-based ROM issue and prefetch queue feeding decode.
module instruction_fetch_unit
  import topaz_geyser_pkg::*;
#(
  parameter  int              IMEM_ADDR_W = 12,
  parameter  int              DEPTH       = 4,
  parameter  logic [XLEN-1:0] RESET_PC    = 32'h0000_0000,
  localparam int              CW          = $clog2(DEPTH + 1)
) (
  input  logic                   clk,
  input  logic                   cpu_rst,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  output logic                   imem_req,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  input  logic [31:0]            imem_rdata,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc0,
  output logic [XLEN-1:0]        out_pc4,
  output logic [31:0]            out_instr,
  output logic [CW-1:0]          queue_count
);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] tag_pc_q, tag_pc_d;
  logic            inflight_q, inflight_d;
  logic            pop_s, push_s, issue_s;
  logic [CW:0]     credit_s;
  fetch_entry_t    push_entry_s;
  fetch_entry_t    head_s;
  logic [CW-1:0]   count_s;

  assign pop_s    = out_valid & out_ready;
  // Slots already promised: queued words plus the word in flight, minus the one leaving now.
  assign credit_s = {1'b0, count_s} + (CW+1)'(inflight_q) - (CW+1)'(pop_s);
  assign issue_s  = cpu_rst & ~redirect_valid & (credit_s < (CW+1)'(DEPTH));
  assign push_s   = cpu_rst & ~redirect_valid & inflight_q;

  assign push_entry_s.pc0   = tag_pc_q;
  assign push_entry_s.instr = imem_rdata;

  fetch_queue #(.DEPTH(DEPTH)) u_queue (
    .clk         (clk),
    .rst_n       (cpu_rst),
    .flush_i     (redirect_valid),
    .push_i      (push_s),
    .push_data_i (push_entry_s),
    .pop_i       (pop_s),
    .count_o     (count_s),
    .head_o      (head_s)
  );

  // Next fetch PC / in-flight tag; a redirect discards the outstanding response.
  always_comb begin
    fetch_pc_d = fetch_pc_q;
    tag_pc_d   = tag_pc_q;
    inflight_d = 1'b0;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
      inflight_d = 1'b0;
    end else if (issue_s) begin
      fetch_pc_d = pc_plus4(fetch_pc_q);
      tag_pc_d   = fetch_pc_q;
      inflight_d = 1'b1;
    end else begin
      fetch_pc_d = fetch_pc_q;
      inflight_d = 1'b0;
    end
  end

  // Fetch state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!cpu_rst) begin
      fetch_pc_q <= RESET_PC;
      tag_pc_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      tag_pc_q   <= tag_pc_d;
      inflight_q <= inflight_d;
    end
  end

  assign imem_req    = issue_s;
  assign imem_addr   = fetch_pc_q[IMEM_ADDR_W-1:0];
  assign queue_count = count_s;
  assign out_valid   = (count_s != '0);
  assign out_pc0     = out_valid ? head_s.pc0            : '0;
  assign out_pc4     = out_valid ? pc_plus4(head_s.pc0)  : '0;
  assign out_instr   = out_valid ? head_s.instr          : 32'h0000_0000;

endmodule
